rom_seq_reader: RTL and testbench
=================================

Name: rom_seq_reader

Overview:
- Upstream address sequencer and read controller for rom_design.
- On a start command, it walks a contiguous address range. For each address it drives rom_design's en/addr, waits out the ROM's registered read latency, and captures the returned word.
- Each word is presented on a valid/ready output stream for the downstream consumer.
- Back-pressure stalls the walk. Only one ROM read is outstanding at any time.

Parameters:
- AW, 4, ROM address width; matches the rom_design addr port.
- DW, 4, ROM data width; matches the rom_design data port.
- READ_LAT, 1, number of clock edges from the edge that samples rom_en high to the edge after which rom_data is valid; legal range is 1 to 4.

Ports:
- clk  in  1  rising-edge clock; shared with rom_design.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  AW  first address of the walk; sampled together with start.
- len  in  AW+1  number of words to read; 0 to 2^AW.
- rom_en  out  1  read enable to rom_design (its en).
- rom_addr  out  AW  address to rom_design (its addr).
- rom_data  in  DW  read data from rom_design (its data).
- out_data  out  DW  captured ROM word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the walk completes.

Behaviour:
- Reset: while rst is high, all outputs go to 0 (rom_en, rom_addr, out_data, out_valid, busy, done) and state goes to IDLE. Reset is asynchronous and applies immediately, including mid-walk. Any in-flight ROM read is discarded.
- All outputs are registered. No combinational path exists from any input to any output.
- FSM states are IDLE, ISSUE, WAIT and HOLD.
- IDLE:
  - start=1 and len>0 at edge E0: load addr=base_addr and remaining=len. Set busy=1. Go to ISSUE, so rom_en=1 and rom_addr=base_addr after E0.
  - start=1 and len=0: set done=1 for one cycle. busy stays 0 and no ROM read occurs.
  - start=0: stay in IDLE.
- ISSUE:
  - Lasts exactly one cycle, with rom_en=1.
  - At the next edge, rom_en goes to 0 and the state goes to WAIT. A latency counter is loaded with READ_LAT.
- WAIT:
  - rom_en=0. The counter decrements each edge.
  - At the edge where the counter reaches 0, capture out_data=rom_data, set out_valid=1, and go to HOLD.
  - Capture therefore occurs at edge E0+1+READ_LAT relative to the issuing edge E0. For READ_LAT=1, capture is 2 edges after issue.
- HOLD:
  - out_valid and out_data stay stable until out_ready is sampled high.
  - At that edge, out_valid goes to 0 and remaining decrements.
  - If remaining was greater than 1: addr becomes addr+1 modulo 2^AW (15 wraps to 0). Go to ISSUE, with rom_en=1 and the new rom_addr after the same edge.
  - If remaining was 1: set done=1 for one cycle and busy=0, then go to IDLE.
- rom_addr holds its last value while rom_en=0.
- Throughput: with out_ready held high, one word per READ_LAT+2 cycles.
- start while busy: ignored and has no effect.
- start in the same cycle as done: ignored, because start is only sampled in IDLE. The earliest new start is accepted one cycle after done.
- len=2^AW: every address is read exactly once, wrapping through the top of the address space.
- out_ready while out_valid=0: ignored.

Test Plan:
The bench models rom_design with data = addr XOR 4'hA and READ_LAT=1.
1. Reset mid-walk: start with base=2 and len=4, then assert rst during the second WAIT → all outputs are 0 immediately. After release the block sits in IDLE with busy=0, and no further rom_en pulses occur.
2. Basic walk: start with base=4'b0010 and len=3, out_ready=1 → rom_addr sequence 2, 3, 4, each with a single-cycle rom_en. out_data sequence 8, 9, E, each with one out_valid pulse. done pulses once after the third handshake. rom_en first rises one cycle after start, and out_valid first rises two cycles after that.
3. Wrap-around: start with base=4'b1100 and len=6 → addresses C, D, E, F, 0, 1 and data 6, 7, 4, 5, A, B.
4. Back-pressure: start with base=0 and len=2, out_ready=0 for 5 cycles after the first out_valid → out_data=A is held stable with out_valid=1 and no second rom_en. After out_ready=1, address 1 is issued on the next edge.
5. Zero length and start while busy: start with len=0 → a one-cycle done pulse, busy stays 0, and rom_en never asserts. Start with base=5 and len=2, then pulse start with base=0 mid-walk → only addresses 5 and 6 are read.
6. Full range: start with base=7 and len=16 → 16 reads covering 7 through F then 0 through 6, each address exactly once. Then one done pulse, with busy low in the cycle after.

Source files
------------

// File: rtl/rom_seq_reader_if.sv
// Command, ROM read bus and output stream of the ROM address sequencer.
// The sequencer uses the master modport; the ROM/consumer side uses slave.
interface rom_seq_reader_if #(
   parameter int AW = 4,
   parameter int DW = 4
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;

   modport master (
      input  start, base_addr, len, rom_data, out_ready,
      output rom_en, rom_addr, out_data, out_valid, busy, done
   );

   modport slave (
      output start, base_addr, len, rom_data, out_ready,
      input  rom_en, rom_addr, out_data, out_valid, busy, done
   );
endinterface

// File: rtl/rom_seq_reader.sv
// Walks a contiguous ROM address range one read at a time and streams each
// returned word out on a valid/ready handshake; back-pressure stalls the walk.
module rom_seq_reader #(
   parameter int AW       = 4,
   parameter int DW       = 4,
   parameter int READ_LAT = 1
) (
   input logic               clk,
   input logic               rst,
   rom_seq_reader_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } state_t;

   localparam logic [2:0]  LAT_INIT = 3'(READ_LAT);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   state_t      state;
   logic [AW:0] remaining;
   logic [2:0]  lat_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         remaining     <= '0;
         lat_cnt       <= '0;
         bus.rom_en    <= 1'b0;
         bus.rom_addr  <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.len != '0) begin
                     bus.rom_addr <= bus.base_addr;
                     remaining    <= bus.len;
                     bus.busy     <= 1'b1;
                     bus.rom_en   <= 1'b1;
                     state        <= ISSUE;
                  end else begin
                     // Empty walk: acknowledge without touching the ROM.
                     bus.done <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               bus.rom_en <= 1'b0;
               lat_cnt    <= LAT_INIT;
               state      <= WAIT;
            end

            WAIT: begin
               // Capture on the edge that takes the counter from 1 to 0.
               if (lat_cnt == 3'd1) begin
                  bus.out_data  <= bus.rom_data;
                  bus.out_valid <= 1'b1;
                  lat_cnt       <= '0;
                  state         <= HOLD;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  remaining     <= remaining - ONE;
                  if (remaining > ONE) begin
                     bus.rom_addr <= bus.rom_addr + 1'b1;
                     bus.rom_en   <= 1'b1;
                     state        <= ISSUE;
                  end else begin
                     bus.done <= 1'b1;
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader against a one-cycle ROM returning addr ^ 4'hA.
module tb_rom_seq_reader;

   logic clk;
   logic rst;

   rom_seq_reader_if #(.AW(4), .DW(4)) bus ();

   rom_seq_reader #(.AW(4), .DW(4), .READ_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [3:0]  en_q[$];
   logic [3:0]  data_q[$];
   int          done_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: registered read, one cycle of latency
   always @(posedge clk) begin
      if (bus.rom_en) bus.rom_data <= bus.rom_addr ^ 4'hA;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rom_en) en_q.push_back(bus.rom_addr);
         if (bus.out_valid && bus.out_ready) data_q.push_back(bus.out_data);
         if (bus.done) done_cnt++;
      end
   end

   task automatic test_reset();
      #1;
      checks++;
      if ({bus.rom_en, bus.rom_addr, bus.out_data, bus.out_valid, bus.busy, bus.done} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0", {bus.rom_en, bus.rom_addr, bus.out_data, bus.out_valid, bus.busy, bus.done});
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_walk();
      bus.out_ready = 1'b1; bus.base_addr = 4'd2; bus.len = 5'd4; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.rom_en !== 1'b0 || bus.rom_addr !== 4'd3 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL midwalk_second_wait got en=%b addr=%h busy=%b want en=0 addr=3 busy=1", bus.rom_en, bus.rom_addr, bus.busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.rom_en, bus.rom_addr, bus.out_data, bus.out_valid, bus.busy, bus.done} !== 12'd0) begin
         errors++;
         $display("FAIL midwalk_async_reset got %b want 0", {bus.rom_en, bus.rom_addr, bus.out_data, bus.out_valid, bus.busy, bus.done});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      en_q.delete(); data_q.delete(); done_cnt = 0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (en_q.size() != 0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL midwalk_after_release got reads=%0d busy=%b valid=%b dones=%0d want 0 0 0 0", en_q.size(), bus.busy, bus.out_valid, done_cnt);
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp_a [3] = '{4'h2, 4'h3, 4'h4};
      logic [3:0] exp_d [3] = '{4'h8, 4'h9, 4'hE};
      logic [3:0] got;
      bit seen = 0;
      en_q.delete(); data_q.delete(); done_cnt = 0;
      bus.out_ready = 1'b1; bus.base_addr = 4'b0010; bus.len = 5'd3; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      checks++;
      if (bus.rom_en !== 1'b1 || bus.rom_addr !== 4'd2 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_first_issue got en=%b addr=%h busy=%b want 1 2 1", bus.rom_en, bus.rom_addr, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rom_en !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_wait got en=%b valid=%b want 0 0", bus.rom_en, bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h8) begin
         errors++;
         $display("FAIL basic_first_capture got valid=%b data=%h want 1 8", bus.out_valid, bus.out_data);
      end
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL basic_done got timeout want done pulse"); end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         got = (i < en_q.size()) ? en_q[i] : 4'hx;
         checks++;
         if (got !== exp_a[i]) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, got, exp_a[i]); end
         got = (i < data_q.size()) ? data_q[i] : 4'hx;
         checks++;
         if (got !== exp_d[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got, exp_d[i]); end
      end
      checks++;
      if (en_q.size() != 3 || data_q.size() != 3 || done_cnt != 1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_counts got reads=%0d words=%0d dones=%0d busy=%b want 3 3 1 0", en_q.size(), data_q.size(), done_cnt, bus.busy);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_a [6] = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
      logic [3:0] exp_d [6] = '{4'h6, 4'h7, 4'h4, 4'h5, 4'hA, 4'hB};
      logic [3:0] got;
      bit seen = 0;
      en_q.delete(); data_q.delete(); done_cnt = 0;
      bus.out_ready = 1'b1; bus.base_addr = 4'b1100; bus.len = 5'd6; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL wrap_done got timeout want done pulse"); end
      for (int i = 0; i < 6; i++) begin
         got = (i < en_q.size()) ? en_q[i] : 4'hx;
         checks++;
         if (got !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, got, exp_a[i]); end
         got = (i < data_q.size()) ? data_q[i] : 4'hx;
         checks++;
         if (got !== exp_d[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, got, exp_d[i]); end
      end
      checks++;
      if (en_q.size() != 6 || data_q.size() != 6) begin
         errors++;
         $display("FAIL wrap_counts got reads=%0d words=%0d want 6 6", en_q.size(), data_q.size());
      end
   endtask

   task automatic test_back_pressure();
      bit seen = 0;
      en_q.delete(); data_q.delete(); done_cnt = 0;
      bus.out_ready = 1'b0; bus.base_addr = 4'd0; bus.len = 5'd2; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA) begin
         errors++;
         $display("FAIL bp_capture got valid=%b data=%h want 1 a", bus.out_valid, bus.out_data);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.rom_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b data=%h en=%b want 1 a 0", i, bus.out_valid, bus.out_data, bus.rom_en);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.rom_en !== 1'b1 || bus.rom_addr !== 4'd1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got en=%b addr=%h valid=%b want 1 1 0", bus.rom_en, bus.rom_addr, bus.out_valid);
      end
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      checks++;
      if (!seen || en_q.size() != 2 || data_q.size() != 2) begin
         errors++;
         $display("FAIL bp_complete got done=%0d reads=%0d words=%0d want 1 2 2", seen, en_q.size(), data_q.size());
      end else begin
         checks++;
         if (data_q[1] !== 4'hB) begin errors++; $display("FAIL bp_second_word got %h want b", data_q[1]); end
      end
   endtask

   task automatic test_zero_len_and_busy_start();
      bit seen = 0;
      en_q.delete(); data_q.delete(); done_cnt = 0;
      bus.out_ready = 1'b1; bus.base_addr = 4'd9; bus.len = 5'd0; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rom_en !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_done got done=%b busy=%b en=%b want 1 0 0", bus.done, bus.busy, bus.rom_en);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || en_q.size() != 0) begin
         errors++;
         $display("FAIL zero_len_after got done=%b reads=%0d want 0 0", bus.done, en_q.size());
      end
      en_q.delete(); done_cnt = 0;
      bus.base_addr = 4'd5; bus.len = 5'd2; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); #1;
      bus.base_addr = 4'd0; bus.len = 5'd3; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (!seen || en_q.size() != 2 || done_cnt != 1) begin
         errors++;
         $display("FAIL busy_start_counts got done=%0d reads=%0d dones=%0d want 1 2 1", seen, en_q.size(), done_cnt);
      end else begin
         checks++;
         if (en_q[0] !== 4'd5 || en_q[1] !== 4'd6) begin
            errors++;
            $display("FAIL busy_start_addrs got %h %h want 5 6", en_q[0], en_q[1]);
         end
      end
   endtask

   task automatic test_full_range();
      logic [3:0] exp_a;
      logic [3:0] got;
      bit seen = 0;
      int bad = 0;
      en_q.delete(); data_q.delete(); done_cnt = 0;
      bus.out_ready = 1'b1; bus.base_addr = 4'd7; bus.len = 5'd16; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            seen = 1;
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got %b want 0", bus.busy); end
         end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL full_done got timeout want done pulse"); end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || done_cnt != 1 || en_q.size() != 16 || data_q.size() != 16) begin
         errors++;
         $display("FAIL full_counts got busy=%b dones=%0d reads=%0d words=%0d want 0 1 16 16", bus.busy, done_cnt, en_q.size(), data_q.size());
      end
      for (int i = 0; i < 16; i++) begin
         exp_a = 4'(7 + i);
         got = (i < en_q.size()) ? en_q[i] : 4'hx;
         if (got !== exp_a) bad++;
         got = (i < data_q.size()) ? data_q[i] : 4'hx;
         if (got !== (exp_a ^ 4'hA)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full_sequence got %0d wrong entries want 0", bad);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
      bus.out_ready = 1'b0; bus.rom_data = '0;
      test_reset();
      test_reset_mid_walk();
      test_basic();
      test_wrap();
      test_back_pressure();
      test_zero_len_and_busy_start();
      test_full_range();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
